// File: rtl/surf_readout_scheduler_pkg.sv
// surf_readout_scheduler_pkg
//   Shared types for the SURF readout scheduler.
//   - SURF_BUF_W / SURF_EVID_W : buffer-ID and event-ID widths
//   - sched_state_t            : command sequencer states
//   - pend_entry_t             : pending command {event_id, buffer}
//   - find_free()              : round-robin search for a free buffer
package surf_readout_scheduler_pkg;

  localparam int SURF_BUF_W   = 2;
  localparam int SURF_EVID_W  = 32;
  localparam int SURF_NUM_BUF = 1 << SURF_BUF_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    HOLDOFF   = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [SURF_EVID_W-1:0] event_id;
    logic [SURF_BUF_W-1:0]  buffer;
  } pend_entry_t;

  // Returns {found, index}. Scans from ptr upward with wrap-around. The loop
  // runs from the farthest offset down so the nearest free buffer wins.
  function automatic logic [SURF_BUF_W:0] find_free(
    input logic [SURF_NUM_BUF-1:0] occ,
    input logic [SURF_BUF_W-1:0]   ptr
  );
    logic [SURF_BUF_W:0]   res;
    logic [SURF_BUF_W-1:0] idx;
    res = '0;
    for (int i = SURF_NUM_BUF - 1; i >= 0; i--) begin
      idx = ptr + SURF_BUF_W'(i);
      if (!occ[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/surf_sched_fifo.sv
// surf_sched_fifo
//   4-deep pending-command FIFO, first-word-fall-through head.
//   Ports:
//     clk_i    : clock (rising edge)
//     rst_n_i  : asynchronous active-low reset (pointers/count only)
//     push_i   : write din_i
//     din_i    : entry to enqueue
//     pop_i    : discard the head entry (ignored when empty)
//     dout_o   : current head entry
//     empty_o  : no entries
//     full_o   : 4 entries held
module surf_sched_fifo
  import surf_readout_scheduler_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  pend_entry_t din_i,
  input  logic        pop_i,
  output pend_entry_t dout_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  pend_entry_t      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (AW+1)'(DEPTH));

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is not reset; only valid slots are ever read by the consumer.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign dout_o = mem[rd_ptr_reg];

endmodule

// File: rtl/surf_readout_scheduler.sv
// surf_readout_scheduler
//   Allocates a free SURF buffer and event ID to each trigger, queues the
//   resulting commands and runs the serializer start/busy/done handshake.
//   Ports:
//     clk_i, rst_n_i        : clock / asynchronous active-low reset
//     trigger_i             : single-cycle trigger request
//     buffer_clear_i/_id_i  : readout releases a buffer
//     cmd_busy_i/cmd_done_i : serializer status
//     cmd_start_o           : one-cycle start pulse
//     cmd_event_id_o        : event ID of the active command
//     cmd_buffer_o          : buffer ID of the active command
//     occupied_o            : per-buffer occupancy
//     trigger_dropped_o     : pulse when a trigger finds no free buffer
//     dead_count_o          : saturating dropped-trigger count
//     timeout_err_o         : sticky done-timeout flag
module surf_readout_scheduler
  import surf_readout_scheduler_pkg::*;
#(
  parameter int          NUM_BUFFERS   = 4,
  parameter logic [31:0] EVENT_ID_INIT = 32'h0000_0000,
  parameter int          DONE_TIMEOUT  = 63
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   trigger_i,
  input  logic                   buffer_clear_i,
  input  logic [SURF_BUF_W-1:0]  buffer_clear_id_i,
  input  logic                   cmd_busy_i,
  input  logic                   cmd_done_i,
  output logic                   cmd_start_o,
  output logic [SURF_EVID_W-1:0] cmd_event_id_o,
  output logic [SURF_BUF_W-1:0]  cmd_buffer_o,
  output logic [NUM_BUFFERS-1:0] occupied_o,
  output logic                   trigger_dropped_o,
  output logic [15:0]            dead_count_o,
  output logic                   timeout_err_o
);

  localparam int              TO_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

  // ---------------- allocation ----------------
  logic [NUM_BUFFERS-1:0]  occupied_vec;
  logic [SURF_BUF_W-1:0]   next_ptr_reg;
  logic [SURF_EVID_W-1:0]  event_ctr_reg;
  logic [SURF_BUF_W:0]     search;
  logic                    alloc_found;
  logic [SURF_BUF_W-1:0]   alloc_idx;
  logic                    accept;
  logic                    drop;
  logic                    dropped_reg;
  logic [15:0]             dead_count_reg;

  assign search      = find_free(occupied_vec, next_ptr_reg);
  assign alloc_found = search[SURF_BUF_W];
  assign alloc_idx   = search[SURF_BUF_W-1:0];
  assign accept      = trigger_i && alloc_found;
  assign drop        = trigger_i && !alloc_found;

  // Allocation only ever picks a free bit, so a set and a clear of the same
  // buffer in one cycle means "clear a free buffer" (no-op) followed by the set.
  for (genvar gi = 0; gi < NUM_BUFFERS; gi++) begin : g_occ
    logic occ_reg;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        occ_reg <= 1'b0;
      end else if (accept && (alloc_idx == SURF_BUF_W'(gi))) begin
        occ_reg <= 1'b1;
      end else if (buffer_clear_i && (buffer_clear_id_i == SURF_BUF_W'(gi))) begin
        occ_reg <= 1'b0;
      end
    end
    assign occupied_vec[gi] = occ_reg;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      next_ptr_reg   <= '0;
      event_ctr_reg  <= EVENT_ID_INIT;
      dropped_reg    <= 1'b0;
      dead_count_reg <= '0;
    end else begin
      dropped_reg <= drop;
      if (accept) begin
        next_ptr_reg  <= alloc_idx + 1'b1;
        event_ctr_reg <= event_ctr_reg + 1'b1;
      end
      if (drop && (dead_count_reg != 16'hFFFF)) begin
        dead_count_reg <= dead_count_reg + 1'b1;
      end
    end
  end

  // ---------------- pending FIFO ----------------
  pend_entry_t push_entry;
  pend_entry_t head_entry;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_pop;

  assign push_entry.event_id = event_ctr_reg;
  assign push_entry.buffer   = alloc_idx;

  surf_sched_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (accept),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .dout_o  (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Every queued entry owns an occupied buffer, so the FIFO can never overflow.
  assert property (@(posedge clk_i) disable iff (!rst_n_i)
                   !(accept && fifo_full && !fifo_pop));

  // ---------------- command sequencer ----------------
  sched_state_t           state_reg, state_next;
  logic                   start_reg, start_next;
  logic                   timeout_reg, timeout_next;
  logic [TO_W-1:0]        wait_cnt_reg, wait_cnt_next;
  logic                   load_cmd;
  logic [SURF_EVID_W-1:0] cmd_event_id_reg;
  logic [SURF_BUF_W-1:0]  cmd_buffer_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg        <= IDLE;
      start_reg        <= 1'b0;
      timeout_reg      <= 1'b0;
      wait_cnt_reg     <= '0;
      cmd_event_id_reg <= '0;
      cmd_buffer_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      start_reg    <= start_next;
      timeout_reg  <= timeout_next;
      wait_cnt_reg <= wait_cnt_next;
      if (load_cmd) begin
        cmd_event_id_reg <= head_entry.event_id;
        cmd_buffer_reg   <= head_entry.buffer;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    start_next    = 1'b0;
    timeout_next  = timeout_reg;
    wait_cnt_next = wait_cnt_reg;
    load_cmd      = 1'b0;
    fifo_pop      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !cmd_busy_i) begin
          load_cmd      = 1'b1;
          start_next    = 1'b1;
          wait_cnt_next = '0;
          state_next    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // wait_cnt counts completed WAIT_DONE cycles; the first one is the
        // cycle cmd_start_o is high.
        if (cmd_done_i) begin
          fifo_pop   = 1'b1;
          state_next = HOLDOFF;
        end else if (wait_cnt_reg == TO_LAST) begin
          fifo_pop     = 1'b1;
          timeout_next = 1'b1;
          state_next   = HOLDOFF;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      HOLDOFF: begin
        // Gives the serializer one cycle to drop busy before we look again.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_start_o       = start_reg;
  assign cmd_event_id_o    = cmd_event_id_reg;
  assign cmd_buffer_o      = cmd_buffer_reg;
  assign occupied_o        = occupied_vec;
  assign trigger_dropped_o = dropped_reg;
  assign dead_count_o      = dead_count_reg;
  assign timeout_err_o     = timeout_reg;

endmodule

// File: tb/tb_surf_readout_scheduler.sv
// tb_surf_readout_scheduler
//   Directed bench for surf_readout_scheduler. Inputs change and outputs are
//   sampled 1 ns after each rising edge.
module tb_surf_readout_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        trigger_i = 1'b0;
  logic        buffer_clear_i = 1'b0;
  logic [1:0]  buffer_clear_id_i = 2'd0;
  logic        cmd_busy_i = 1'b0;
  logic        cmd_done_i = 1'b0;
  logic        cmd_start_o;
  logic [31:0] cmd_event_id_o;
  logic [1:0]  cmd_buffer_o;
  logic [3:0]  occupied_o;
  logic        trigger_dropped_o;
  logic [15:0] dead_count_o;
  logic        timeout_err_o;

  surf_readout_scheduler dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .trigger_i         (trigger_i),
    .buffer_clear_i    (buffer_clear_i),
    .buffer_clear_id_i (buffer_clear_id_i),
    .cmd_busy_i        (cmd_busy_i),
    .cmd_done_i        (cmd_done_i),
    .cmd_start_o       (cmd_start_o),
    .cmd_event_id_o    (cmd_event_id_o),
    .cmd_buffer_o      (cmd_buffer_o),
    .occupied_o        (occupied_o),
    .trigger_dropped_o (trigger_dropped_o),
    .dead_count_o      (dead_count_o),
    .timeout_err_o     (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int last_done = -100;

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (cmd_start_o === 1'b1) start_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},   32'(cmd_start_o),       32'd0);
    check({tag, "_evid"},    cmd_event_id_o,         32'd0);
    check({tag, "_buf"},     32'(cmd_buffer_o),      32'd0);
    check({tag, "_occ"},     32'(occupied_o),        32'd0);
    check({tag, "_drop"},    32'(trigger_dropped_o), 32'd0);
    check({tag, "_dead"},    32'(dead_count_o),      32'd0);
    check({tag, "_timeout"}, 32'(timeout_err_o),     32'd0);
  endtask

  // Bounded wait for the next start pulse.
  task automatic wait_start(output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cmd_start_o === 1'b1) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    check("start_seen", 32'(found), 32'd1);
  endtask

  // Let the serializer accept one command, check it, then return done.
  task automatic serve(input logic [31:0] ev, input logic [1:0] b);
    int s;
    cmd_busy_i = 1'b0;
    wait_start(s);
    $display("start at cycle %0d: event_id=%0d buffer=%0d", s, cmd_event_id_o, cmd_buffer_o);
    check("serve_gap_ge2", 32'(s - last_done >= 2), 32'd1);
    check("serve_evid", cmd_event_id_o, ev);
    check("serve_buf", 32'(cmd_buffer_o), 32'(b));
    cmd_busy_i = 1'b1;
    run(4);
    check("serve_evid_hold", cmd_event_id_o, ev);
    cmd_done_i = 1'b1;
    last_done = cyc;
    step();
    cmd_done_i = 1'b0;
    cmd_busy_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
  endtask

  initial begin
    int s0;
    int s;

    // ---- reset state ----
    run(2);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    step();

    // ---- single trigger, done 36 cycles after start ----
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    check("t1_occ", 32'(occupied_o), 32'h1);
    check("t1_no_start_yet", 32'(cmd_start_o), 32'd0);
    step();
    check("t1_start", 32'(cmd_start_o), 32'd1);
    check("t1_evid", cmd_event_id_o, 32'd0);
    check("t1_buf", 32'(cmd_buffer_o), 32'd0);
    cmd_busy_i = 1'b1;
    s0 = start_cnt;
    run(36);
    check("t1_single_start", 32'(start_cnt - s0), 32'd0);
    cmd_done_i = 1'b1;
    last_done = cyc;
    step();
    cmd_done_i = 1'b0;
    cmd_busy_i = 1'b0;
    check("t1_occ_kept", 32'(occupied_o), 32'h1);
    check("t1_no_timeout", 32'(timeout_err_o), 32'd0);

    // ---- four back-to-back triggers, serializer busy ----
    do_reset();
    cmd_busy_i = 1'b1;
    trigger_i = 1'b1;
    run(4);
    trigger_i = 1'b0;
    check("t2_occ_full", 32'(occupied_o), 32'hF);
    check("t2_dead0", 32'(dead_count_o), 32'd0);

    // ---- fifth trigger is dropped ----
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    check("t3_dropped", 32'(trigger_dropped_o), 32'd1);
    check("t3_dead1", 32'(dead_count_o), 32'd1);
    check("t3_occ", 32'(occupied_o), 32'hF);
    step();
    check("t3_drop_pulse_end", 32'(trigger_dropped_o), 32'd0);

    for (int k = 0; k < 4; k++) serve(32'(k), 2'(k));
    s0 = start_cnt;
    run(5);
    check("t2_no_extra_start", 32'(start_cnt - s0), 32'd0);
    check("t2_occ_after", 32'(occupied_o), 32'hF);

    // ---- clear buffer 1 then trigger (next_ptr is 0) ----
    buffer_clear_i = 1'b1;
    buffer_clear_id_i = 2'd1;
    step();
    buffer_clear_i = 1'b0;
    check("t4_occ_cleared", 32'(occupied_o), 32'hD);
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    check("t4_occ_refull", 32'(occupied_o), 32'hF);
    serve(32'd4, 2'd1);

    // ---- trigger and clear in the same cycle while full ----
    trigger_i = 1'b1;
    buffer_clear_i = 1'b1;
    buffer_clear_id_i = 2'd2;
    step();
    trigger_i = 1'b0;
    buffer_clear_i = 1'b0;
    check("t4b_dropped", 32'(trigger_dropped_o), 32'd1);
    check("t4b_dead2", 32'(dead_count_o), 32'd2);
    check("t4b_occ", 32'(occupied_o), 32'hB);
    s0 = start_cnt;
    run(4);
    check("t4b_no_start", 32'(start_cnt - s0), 32'd0);

    // ---- done timeout ----
    cmd_busy_i = 1'b1;
    buffer_clear_i = 1'b1;
    buffer_clear_id_i = 2'd3;
    step();
    buffer_clear_i = 1'b0;
    check("t5_occ_clr3", 32'(occupied_o), 32'h3);
    trigger_i = 1'b1;
    run(2);
    trigger_i = 1'b0;
    check("t5_occ_full", 32'(occupied_o), 32'hF);
    cmd_busy_i = 1'b0;
    wait_start(s);
    check("t5_evid", cmd_event_id_o, 32'd5);
    check("t5_buf", 32'(cmd_buffer_o), 32'd2);
    run(62);
    check("t5_no_timeout_yet", 32'(timeout_err_o), 32'd0);
    check("t5_evid_hold", cmd_event_id_o, 32'd5);
    step();
    check("t5_timeout_set", 32'(timeout_err_o), 32'd1);
    step();
    check("t5_holdoff_no_start", 32'(cmd_start_o), 32'd0);
    step();
    check("t5_next_start", 32'(cmd_start_o), 32'd1);
    check("t5_next_evid", cmd_event_id_o, 32'd6);
    check("t5_next_buf", 32'(cmd_buffer_o), 32'd3);
    check("t5_timeout_sticky", 32'(timeout_err_o), 32'd1);

    // ---- reset mid WAIT_DONE ----
    run(3);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_all_zero("t6_async");
    step();
    rst_n_i = 1'b1;
    step();
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    check("t6_occ", 32'(occupied_o), 32'h1);
    step();
    check("t6_start", 32'(cmd_start_o), 32'd1);
    check("t6_evid", cmd_event_id_o, 32'd0);
    check("t6_buf", 32'(cmd_buffer_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
